hard_reset_receiver: RTL
========================

HARD_RESET_RECEIVER -- requirements
Module: hard_reset_receiver

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 10, meaning the number of CLK cycles allowed for the policy engine to acknowledge a received reset.
REQ-002 The block SHALL have port CLK  in  1  single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port PHY_HR_Detect  in  1  single-cycle pulse from the PHY: Hard Reset ordered set received.
REQ-005 The block SHALL have port PHY_CR_Detect  in  1  single-cycle pulse from the PHY: Cable Reset ordered set received.
REQ-006 The block SHALL have port iRECEIVE_DETECT  in  8  RECEIVE_DETECT write data (bit5 = Hard Reset enable, bit6 = Cable Reset enable).
REQ-007 The block SHALL have port RD_Write  in  1  write strobe for iRECEIVE_DETECT.
REQ-008 The block SHALL have port RX_Msg_Valid  in  1  pulse marking iRX_Byte_Count valid.
REQ-009 The block SHALL have port iRX_Byte_Count  in  8  byte count of the last received message.
REQ-010 The block SHALL have port PE_HR_Complete  in  1  policy-engine acknowledge that reset handling is done.
REQ-011 The block SHALL have port iALERT_Clear  in  16  write-1-to-clear mask for ALERT.
REQ-012 The block SHALL have port ALERT  out  16  sticky alert register (bit3 ReceivedHardReset, bit9 Fault).
REQ-013 The block SHALL have port oRECEIVE_DETECT  out  8  RECEIVE_DETECT register.
REQ-014 The block SHALL have port oRECEIVE_BYTE_COUNT  out  8  RECEIVE_BYTE_COUNT register.
REQ-015 The block SHALL have port PE_HR_Indication  out  1  level indication of a reset to the policy engine.
REQ-016 The block SHALL have port HR_Type  out  1  reset type: 0 = Hard Reset, 1 = Cable Reset.
REQ-017 The block SHALL have port PHY_Reset_Done  out  1  single-cycle pulse on successful completion.

Function
REQ-018 The state machine SHALL be one-hot with states IDLE, WAIT_DETECT, INDICATE, WAIT_PE, COMPLETE and TIMEOUT, and SHALL use registered state with next-state logic.
REQ-019 IDLE SHALL transition unconditionally to WAIT_DETECT on the next cycle.
REQ-020 In WAIT_DETECT, a Cable Reset SHALL be accepted when PHY_CR_Detect=1 and oRECEIVE_DETECT[6]=1: HR_Type is set to 1 and the next state is INDICATE.
REQ-021 In WAIT_DETECT, a Hard Reset SHALL be accepted when PHY_HR_Detect=1 and oRECEIVE_DETECT[5]=1: HR_Type is set to 0 and the next state is INDICATE.
REQ-022 When both detects are enabled and asserted in the same cycle, the Cable Reset SHALL win.
REQ-023 A detect pulse whose enable bit is 0 SHALL be ignored.
REQ-024 Detect pulses SHALL be ignored in every state other than WAIT_DETECT and SHALL NOT be queued.
REQ-025 INDICATE SHALL last one cycle: oRECEIVE_DETECT is cleared to 0, oRECEIVE_BYTE_COUNT is cleared to 0, ALERT[3] is set, PE_HR_Indication is set to 1, the wait counter is cleared, and the next state is WAIT_PE.
REQ-026 In WAIT_PE, an 8-bit wait counter SHALL increment by 1 per cycle and SHALL saturate at 255.
REQ-027 In WAIT_PE, PE_HR_Complete=1 SHALL move the state to COMPLETE; otherwise, a counter value of TIMEOUT-1 SHALL move the state to TIMEOUT.
REQ-028 If PE_HR_Complete=1 in the same cycle the counter reaches TIMEOUT-1, COMPLETE SHALL win.
REQ-029 COMPLETE SHALL last one cycle: PE_HR_Indication goes to 0, PHY_Reset_Done pulses 1 for exactly that cycle, and the next state is WAIT_DETECT.
REQ-030 TIMEOUT SHALL last one cycle: PE_HR_Indication goes to 0, ALERT[9] is set, PHY_Reset_Done stays 0, and the next state is WAIT_DETECT.
REQ-031 A RD_Write pulse SHALL load oRECEIVE_DETECT from iRECEIVE_DETECT in any state.
REQ-032 If RD_Write coincides with INDICATE, the clear SHALL win.
REQ-033 After a reset is accepted, further detects SHALL remain disabled until software rewrites oRECEIVE_DETECT.
REQ-034 RX_Msg_Valid SHALL load oRECEIVE_BYTE_COUNT from iRX_Byte_Count only in WAIT_DETECT, and SHALL be ignored in all other states.
REQ-035 ALERT bits SHALL be sticky and SHALL be cleared where iALERT_Clear bits are 1.
REQ-036 When an ALERT bit is set and cleared in the same cycle, the set SHALL win.
REQ-037 ALERT bits other than 3 and 9 SHALL never be set by this block.
REQ-038 HR_Type SHALL hold its value until the next accepted reset.

Reset
REQ-039 While reset=0, the state SHALL be IDLE, ALERT=16'h0000, oRECEIVE_DETECT=8'h00, oRECEIVE_BYTE_COUNT=8'h00, PE_HR_Indication=0, HR_Type=0, PHY_Reset_Done=0 and the counter=0, asynchronously.
REQ-040 Reset asserted mid-operation, in any state, SHALL abort immediately to these values with no PHY_Reset_Done pulse.

Verification
REQ-041 Write iRECEIVE_DETECT=8'h20, then pulse PHY_HR_Detect, then assert PE_HR_Complete 3 cycles later -> ALERT=16'h0008, oRECEIVE_DETECT=8'h00, HR_Type=0, and a single PHY_Reset_Done pulse.
REQ-042 Write iRECEIVE_DETECT=8'h60, then pulse PHY_HR_Detect and PHY_CR_Detect in the same cycle -> HR_Type=1 and PE_HR_Indication=1 for WAIT_PE duration.
REQ-043 Write iRECEIVE_DETECT=8'h20 and pulse PHY_HR_Detect, then never assert PE_HR_Complete -> after TIMEOUT cycles, ALERT=16'h0208, no PHY_Reset_Done pulse, and the state returns to WAIT_DETECT.
REQ-044 With iRECEIVE_DETECT=8'h00, pulse PHY_HR_Detect -> no state change and ALERT stays 0; after one completed Hard Reset, a second Hard Reset pulse without a rewrite -> ignored.
REQ-045 Pulse iALERT_Clear=16'h0008 in the same cycle as INDICATE -> ALERT[3]=1; pulse it the following cycle -> ALERT[3]=0.
REQ-046 Drive reset=0 during WAIT_PE -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hard_reset_receiver.sv
// Hard/Cable Reset receiver: accepts enabled PHY reset detects, hands off to the policy engine, flags ALERT.
// One cycle detect->INDICATE, one cycle INDICATE->WAIT_PE; no backpressure, detects outside WAIT_DETECT are dropped.
module hard_reset_receiver #(
    parameter int TIMEOUT = 10
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        PHY_HR_Detect,
    input  logic        PHY_CR_Detect,
    input  logic [7:0]  iRECEIVE_DETECT,
    input  logic        RD_Write,
    input  logic        RX_Msg_Valid,
    input  logic [7:0]  iRX_Byte_Count,
    input  logic        PE_HR_Complete,
    input  logic [15:0] iALERT_Clear,
    output logic [15:0] ALERT,
    output logic [7:0]  oRECEIVE_DETECT,
    output logic [7:0]  oRECEIVE_BYTE_COUNT,
    output logic        PE_HR_Indication,
    output logic        HR_Type,
    output logic        PHY_Reset_Done
);

    typedef enum logic [5:0] {
        S_IDLE        = 6'b000001,
        S_WAIT_DETECT = 6'b000010,
        S_INDICATE    = 6'b000100,
        S_WAIT_PE     = 6'b001000,
        S_COMPLETE    = 6'b010000,
        S_TIMEOUT     = 6'b100000
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [15:0] r_alert;
    logic [7:0]  r_rd;
    logic [7:0]  r_bc;
    logic        r_pe_ind;
    logic        r_hr_type;
    logic        r_done;
    logic        w_cr_acc;
    logic        w_hr_acc;
    logic [15:0] w_alert_set;

    assign w_cr_acc    = PHY_CR_Detect & r_rd[6];
    assign w_hr_acc    = PHY_HR_Detect & r_rd[5];
    assign w_alert_set = {6'b0, r_state == S_TIMEOUT, 5'b0, r_state == S_INDICATE, 3'b0};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:        w_state_nxt = S_WAIT_DETECT;
            S_WAIT_DETECT: if (w_cr_acc || w_hr_acc) w_state_nxt = S_INDICATE;
            S_INDICATE:    w_state_nxt = S_WAIT_PE;
            S_WAIT_PE: begin
                // Policy-engine acknowledge takes priority over an expiring counter.
                if (PE_HR_Complete)            w_state_nxt = S_COMPLETE;
                else if (r_cnt == LP_CNT_LAST) w_state_nxt = S_TIMEOUT;
            end
            S_COMPLETE:    w_state_nxt = S_WAIT_DETECT;
            S_TIMEOUT:     w_state_nxt = S_WAIT_DETECT;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'h00;
            r_alert   <= 16'h0000;
            r_rd      <= 8'h00;
            r_bc      <= 8'h00;
            r_pe_ind  <= 1'b0;
            r_hr_type <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // Set wins over a simultaneous write-1-to-clear.
            r_alert  <= (r_alert & ~iALERT_Clear) | w_alert_set;
            r_pe_ind <= (w_state_nxt == S_WAIT_PE);
            r_done   <= (w_state_nxt == S_COMPLETE);

            if (r_state == S_INDICATE)  r_rd <= 8'h00;
            else if (RD_Write)          r_rd <= iRECEIVE_DETECT;

            if (r_state == S_INDICATE)                          r_bc <= 8'h00;
            else if (RX_Msg_Valid && r_state == S_WAIT_DETECT)  r_bc <= iRX_Byte_Count;

            if (r_state == S_WAIT_DETECT) begin
                if (w_cr_acc)      r_hr_type <= 1'b1;
                else if (w_hr_acc) r_hr_type <= 1'b0;
            end

            if (r_state == S_INDICATE)                          r_cnt <= 8'h00;
            else if (r_state == S_WAIT_PE && r_cnt != 8'hFF)    r_cnt <= r_cnt + 8'd1;
        end
    end

    assign ALERT               = r_alert;
    assign oRECEIVE_DETECT     = r_rd;
    assign oRECEIVE_BYTE_COUNT = r_bc;
    assign PE_HR_Indication    = r_pe_ind;
    assign HR_Type             = r_hr_type;
    assign PHY_Reset_Done      = r_done;

endmodule
